// File: rtl/coffee_pkg.sv
// Shared encodings for the brew scheduler: drink types, scheduler states,
// panel ids and the per-drink phase ordering.
package coffee_pkg;

  typedef enum logic [1:0] {
    NO_COFFEE    = 2'd0,
    EXPR_COFFEE  = 2'd1,
    LATTE_COFFEE = 2'd2,
    CAPP_COFFEE  = 2'd3
  } drink_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGrind = 3'd1,
    StBrew  = 3'd2,
    StMilk  = 3'd3,
    StFoam  = 3'd4,
    StDone  = 3'd5
  } sched_state_e;

  localparam logic PANEL_A = 1'b0;
  localparam logic PANEL_B = 1'b1;

  // Phase that follows a finished timed phase for the captured drink.
  function automatic sched_state_e next_phase(sched_state_e cur, drink_e drink);
    sched_state_e nxt;
    case (cur)
      StGrind: nxt = StBrew;
      StBrew:  nxt = (drink == EXPR_COFFEE) ? StDone : StMilk;
      StMilk:  nxt = (drink == CAPP_COFFEE) ? StFoam : StDone;
      default: nxt = StDone;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/brew_phase_timer.sv
// Loadable down-counter timing one brew phase. Counts down to zero and holds.
module brew_phase_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic [Width-1:0] o_value,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  // Load takes priority; otherwise decrement until zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_value = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/brew_scheduler.sv
// Round-robin scheduler sharing one brew unit between panels A and B.
// Optional abort support is enabled with the BREW_ABORT_EN macro.
module brew_scheduler
  import coffee_pkg::*;
#(
  parameter int unsigned GRIND_CYC = 4,
  parameter int unsigned BREW_CYC  = 6,
  parameter int unsigned MILK_CYC  = 3,
  parameter int unsigned FOAM_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [1:0] type_a,
  input  logic       req_b,
  input  logic [1:0] type_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       grind,
  output logic       brew,
  output logic       milk,
  output logic       foam,
  output logic       done_a,
  output logic       done_b,
`ifdef BREW_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy
);

  localparam int unsigned MaxAB  = (GRIND_CYC > BREW_CYC) ? GRIND_CYC : BREW_CYC;
  localparam int unsigned MaxCD  = (MILK_CYC > FOAM_CYC) ? MILK_CYC : FOAM_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned TW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TW-1:0] GrindLd = TW'(GRIND_CYC - 1);
  localparam logic [TW-1:0] BrewLd  = TW'(BREW_CYC - 1);
  localparam logic [TW-1:0] MilkLd  = TW'(MILK_CYC - 1);
  localparam logic [TW-1:0] FoamLd  = TW'(FOAM_CYC - 1);

  // A zero-length phase cannot be sequenced; reject it at elaboration.
  if (GRIND_CYC == 0 || BREW_CYC == 0 || MILK_CYC == 0 || FOAM_CYC == 0) begin : g_bad_cyc
    $error("brew_scheduler: all *_CYC parameters must be >= 1");
  end

  function automatic logic [TW-1:0] phase_load(sched_state_e st);
    logic [TW-1:0] ld;
    case (st)
      StGrind: ld = GrindLd;
      StBrew:  ld = BrewLd;
      StMilk:  ld = MilkLd;
      StFoam:  ld = FoamLd;
      default: ld = '0;
    endcase
    return ld;
  endfunction

  sched_state_e  r_state;
  sched_state_e  w_state_d;
  drink_e        r_type;
  logic          r_owner;
  logic          r_prio_b;   // 1: B wins a tie (A was served last)
  logic          r_gnt_a, r_gnt_b;
  logic          r_grind, r_brew, r_milk, r_foam;
  logic          r_done_a, r_done_b;
  logic          w_valid_a, w_valid_b;
  logic          w_pick_a, w_pick_b;
  logic          w_grant;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_load_val;
  logic [TW-1:0] w_tmr_value;
  logic          w_tmr_zero;
`ifdef BREW_ABORT_EN
  logic          w_abort_hit;
  logic          r_aborted;
`endif

  brew_phase_timer #(
    .Width (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_value    (w_tmr_value),
    .o_zero     (w_tmr_zero)
  );

  // Arbitration, next state and timer reload decisions.
  always_comb begin
    w_valid_a      = req_a && (drink_e'(type_a) != NO_COFFEE);
    w_valid_b      = req_b && (drink_e'(type_b) != NO_COFFEE);
    w_pick_a       = w_valid_a && (!w_valid_b || !r_prio_b);
    w_pick_b       = w_valid_b && !w_pick_a;
    w_grant        = (r_state == StIdle) && (w_pick_a || w_pick_b);
    w_state_d      = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
`ifdef BREW_ABORT_EN
    w_abort_hit    = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_d      = StGrind;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = GrindLd;
        end
      end
      StGrind, StBrew, StMilk, StFoam: begin
`ifdef BREW_ABORT_EN
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_d   = StIdle;
        end else
`endif
        if (w_tmr_zero) begin
          w_state_d      = next_phase(r_state, r_type);
          w_tmr_load     = (w_state_d != StDone);
          w_tmr_load_val = phase_load(w_state_d);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, captured order and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_type   <= NO_COFFEE;
      r_owner  <= PANEL_A;
      r_prio_b <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_grind  <= 1'b0;
      r_brew   <= 1'b0;
      r_milk   <= 1'b0;
      r_foam   <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
`ifdef BREW_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_gnt_a <= w_grant && w_pick_a;
      r_gnt_b <= w_grant && w_pick_b;
      if (w_grant) begin
        r_owner  <= w_pick_b ? PANEL_B : PANEL_A;
        r_type   <= w_pick_b ? drink_e'(type_b) : drink_e'(type_a);
        r_prio_b <= w_pick_a;
      end
      r_grind  <= (w_state_d == StGrind);
      r_brew   <= (w_state_d == StBrew);
      r_milk   <= (w_state_d == StMilk);
      r_foam   <= (w_state_d == StFoam);
      r_done_a <= (w_state_d == StDone) && (r_owner == PANEL_A);
      r_done_b <= (w_state_d == StDone) && (r_owner == PANEL_B);
`ifdef BREW_ABORT_EN
      r_aborted <= w_abort_hit;
`endif
    end
  end

  // The timer is always loaded with at most the active phase length minus one.
  a_timer_range: assert property (@(posedge clk) disable iff (rst)
    (r_state == StGrind || r_state == StBrew || r_state == StMilk || r_state == StFoam)
    |-> (w_tmr_value <= phase_load(r_state)));

  assign gnt_a  = r_gnt_a;
  assign gnt_b  = r_gnt_b;
  assign grind  = r_grind;
  assign brew   = r_brew;
  assign milk   = r_milk;
  assign foam   = r_foam;
  assign done_a = r_done_a;
  assign done_b = r_done_b;
  assign busy   = (r_state != StIdle);
`ifdef BREW_ABORT_EN
  assign aborted = r_aborted;
`endif

endmodule

// File: tb/tb_brew_scheduler.sv
// Directed bench for brew_scheduler at default phase lengths (4/6/3/2).
// Abort scenario is included when BREW_ABORT_EN is defined.
module tb_brew_scheduler;

  localparam int G = 4;
  localparam int B = 6;
  localparam int M = 3;
  localparam int F = 2;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] type_a, type_b;
  logic       gnt_a, gnt_b, grind, brew, milk, foam, done_a, done_b, busy;
`ifdef BREW_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_overlap = 0;
  int cnt_gnt_a = 0, cnt_gnt_b = 0, cnt_done_a = 0, cnt_done_b = 0;

  brew_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .type_a (type_a),
    .req_b  (req_b),
    .type_b (type_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .grind  (grind),
    .brew   (brew),
    .milk   (milk),
    .foam   (foam),
    .done_a (done_a),
    .done_b (done_b),
`ifdef BREW_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping and mutual-exclusion watch.
  always @(negedge clk) begin
    if (!rst) begin
      if ((gnt_a && gnt_b) || (done_a && done_b)) n_overlap++;
      if (gnt_a)  cnt_gnt_a++;
      if (gnt_b)  cnt_gnt_b++;
      if (done_a) cnt_done_a++;
      if (done_b) cnt_done_b++;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // {gnt_a,gnt_b,grind,brew,milk,foam,done_a,done_b,busy}
  function automatic int out_vec();
    return {23'd0, gnt_a, gnt_b, grind, brew, milk, foam, done_a, done_b, busy};
  endfunction

  function automatic int exp_vec(input bit pnl_b, input int drink, input int k);
    int len;
    int v;
    len = G + B + ((drink >= 2) ? M : 0) + ((drink == 3) ? F : 0);
    v = 0;
    if (k == 0) v |= pnl_b ? (1 << 7) : (1 << 8);
    if (k < G) v |= (1 << 6);
    else if (k < G + B) v |= (1 << 5);
    else if (k < len && k < G + B + M) v |= (1 << 4);
    else if (k < len) v |= (1 << 3);
    if (k == len) v |= pnl_b ? (1 << 1) : (1 << 2);
    if (k <= len) v |= 1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_a = 1'b0; type_a = 2'd0;
    req_b = 1'b0; type_b = 2'd0;
`ifdef BREW_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for a grant to the given panel and checks its latency.
  task automatic wait_gnt(input bit pnl_b, input int exp_lat, input string tag);
    for (int i = 0; i <= exp_lat + 8; i++) begin
      if (pnl_b ? gnt_b : gnt_a) begin
        check(tag, i, exp_lat);
        return;
      end
      @(negedge clk);
    end
    check(tag, -1, exp_lat);
  endtask

  // Called at the grant cycle; checks every cycle through the following IDLE cycle.
  task automatic check_order(input bit pnl_b, input int drink, input string tag);
    int len;
    len = G + B + ((drink >= 2) ? M : 0) + ((drink == 3) ? F : 0);
    for (int k = 0; k <= len + 1; k++) begin
      check($sformatf("%s_k%0d", tag, k), out_vec(), exp_vec(pnl_b, drink, k));
      @(negedge clk);
    end
  endtask

  int snap;

  initial begin
    rst = 1'b1;
    req_a = 1'b0; type_a = 2'd0;
    req_b = 1'b0; type_b = 2'd0;
`ifdef BREW_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    do_reset();
    check("idle_outputs", out_vec(), 0);

    // Single espresso from A.
    req_a = 1'b1; type_a = 2'd1;
    @(negedge clk);
    wait_gnt(1'b0, 0, "t1_gnt_a");
    req_a = 1'b0; type_a = 2'd0;
    check_order(1'b0, 1, "t1_expr");

    // Simultaneous cappuccino A / latte B after reset: A first, then B.
    do_reset();
    req_a = 1'b1; type_a = 2'd3;
    req_b = 1'b1; type_b = 2'd2;
    @(negedge clk);
    wait_gnt(1'b0, 0, "t2_gnt_a");
    req_a = 1'b0; type_a = 2'd0;
    check_order(1'b0, 3, "t2_capp_a");
    wait_gnt(1'b1, 0, "t2_gnt_b");
    req_b = 1'b0; type_b = 2'd0;
    check_order(1'b1, 2, "t2_latte_b");

    // Continuous requests from both panels alternate.
    do_reset();
    req_a = 1'b1; type_a = 2'd1;
    req_b = 1'b1; type_b = 2'd1;
    @(negedge clk);
    wait_gnt(1'b0, 0, "t3_gnt0_a");
    @(negedge clk);
    wait_gnt(1'b1, G + B + 1, "t3_gnt1_b");
    @(negedge clk);
    wait_gnt(1'b0, G + B + 1, "t3_gnt2_a");
    @(negedge clk);
    wait_gnt(1'b1, G + B + 1, "t3_gnt3_b");
    req_a = 1'b0; req_b = 1'b0;
    repeat (14) @(negedge clk);

    // Type 0 request from A is ignored.
    do_reset();
    snap = cnt_gnt_a;
    req_a = 1'b1; type_a = 2'd0;
    req_b = 1'b1; type_b = 2'd1;
    @(negedge clk);
    wait_gnt(1'b1, 0, "t4_gnt_b");
    req_b = 1'b0; type_b = 2'd0;
    repeat (20) @(negedge clk);
    check("t4_no_gnt_a", cnt_gnt_a - snap, 0);
    check("t4_idle", out_vec(), 0);
    req_a = 1'b0;

    // Reset during BREW of a latte, then a pending A runs a full sequence.
    do_reset();
    req_a = 1'b1; type_a = 2'd2;
    @(negedge clk);
    wait_gnt(1'b0, 0, "t5_gnt_a");
    req_a = 1'b0; type_a = 2'd0;
    repeat (6) @(negedge clk);
    check("t5_in_brew", out_vec(), exp_vec(1'b0, 2, 6));
    snap = cnt_done_a + cnt_done_b;
    req_a = 1'b1; type_a = 2'd3;
    rst = 1'b1;
    #1;
    check("t5_async_clear", out_vec(), 0);
    @(negedge clk);
    check("t5_held_clear", out_vec(), 0);
    rst = 1'b0;
    check("t5_no_done", cnt_done_a + cnt_done_b - snap, 0);
    @(negedge clk);
    wait_gnt(1'b0, 0, "t5_regnt_a");
    req_a = 1'b0; type_a = 2'd0;
    check_order(1'b0, 3, "t5_capp_a");

`ifdef BREW_ABORT_EN
    // Abort during MILK of a latte.
    do_reset();
    req_a = 1'b1; type_a = 2'd2;
    @(negedge clk);
    wait_gnt(1'b0, 0, "t6_gnt_a");
    req_a = 1'b0; type_a = 2'd0;
    repeat (G + B) @(negedge clk);
    check("t6_in_milk", out_vec(), exp_vec(1'b0, 2, G + B));
    snap = cnt_done_a + cnt_done_b;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_aborted_hi", int'(aborted), 1);
    check("t6_outputs_off", out_vec(), 0);
    @(negedge clk);
    check("t6_aborted_lo", int'(aborted), 0);
    repeat (5) @(negedge clk);
    check("t6_no_done", cnt_done_a + cnt_done_b - snap, 0);
`endif

    check("no_overlap", n_overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
